if_fetch_queue: RTL and testbench



---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 56 +++++
 rtl/if_fetch_queue.sv | 155 +++++++++++++++
 tb/tb_if_fetch_queue.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch queue
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] ins;
  } fetch_entry_t;

  localparam logic [31:0] BUBBLE_INS = 32'h0000_0000;
  localparam logic [31:0] PC_STEP    = 32'd4;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous prefetch FIFO of fetch entries
// Flush has priority over push and pop; DEPTH must be a power of two.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     Rst,
  input  logic                     push,
  input  fetch_entry_t             din,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output fetch_entry_t             head
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_wr;
  logic          w_rd;

  assign w_rd  = pop & ~empty;
  assign w_wr  = push & (~full | w_rd);
  assign count = r_count;
  assign empty = (r_count == '0);
  assign full  = (r_count == (AW+1)'(DEPTH));
  assign head  = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (Rst || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= din;
  end

endmodule

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - instruction fetch front end with prefetch FIFO and redirect handling
// Define IF_FETCH_BYPASS_EN to let a response skip an empty FIFO straight into ins.
module if_fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        hz,
  input  logic        f_stall,
  input  logic        mem_hold,
  input  logic        branch,
  input  logic [31:0] branoff,
  input  logic        trigger_trap,
  input  logic [31:0] mtvec,
  input  logic        trigger_trap_ret,
  input  logic [31:0] mepc,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_dout,
  output logic [31:0] ins,
  output logic [31:0] IF_ID_pres_addr
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t r_state;
  logic [31:0]  r_fetch_pc;
  logic         r_inflight;
  logic [31:0]  r_inflight_addr;
  logic         r_imem_en;
  logic [31:0]  r_imem_addr;
  logic [31:0]  r_ins;
  logic [31:0]  r_pres_addr;

  logic         w_adv;
  logic         w_redirect;
  logic [31:0]  w_target;
  logic         w_bypass;
  logic         w_push;
  logic         w_pop;
  logic         w_load;
  logic         w_credit;
  logic         w_empty;
  logic         w_full;
  logic [CW-1:0] w_count;
  logic [CW:0]  w_occ_next;
  fetch_entry_t w_resp;
  fetch_entry_t w_head;
  fetch_entry_t w_load_entry;

  assign w_adv      = ~(hz | f_stall | mem_hold);
  assign w_redirect = trigger_trap | trigger_trap_ret | branch;
  assign w_target   = trigger_trap     ? mtvec :
                      trigger_trap_ret ? mepc  : branoff;

  always_comb begin
    w_resp      = '0;
    w_resp.addr = r_inflight_addr;
    w_resp.ins  = imem_dout;
  end

`ifdef IF_FETCH_BYPASS_EN
  assign w_bypass = w_adv & w_empty & r_inflight;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push       = r_inflight & ~w_bypass;
  assign w_pop        = w_adv & ~w_empty & ~w_redirect;
  assign w_load       = w_adv & (~w_empty | w_bypass);
  assign w_load_entry = w_bypass ? w_resp : w_head;

  // The request being presented now lands next cycle, so it already owns a slot.
  assign w_occ_next = {1'b0, w_count} + (CW+1)'(w_push) - (CW+1)'(w_pop)
                    + (CW+1)'(r_imem_en);
  assign w_credit   = w_occ_next < (CW+1)'(DEPTH);

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .Rst   (Rst),
    .push  (w_push),
    .din   (w_resp),
    .pop   (w_pop),
    .flush (w_redirect),
    .count (w_count),
    .empty (w_empty),
    .full  (w_full),
    .head  (w_head)
  );

  always_ff @(posedge clk) begin
    if (Rst) begin
      r_state         <= IDLE;
      r_fetch_pc      <= RESET_PC;
      r_inflight      <= 1'b0;
      r_inflight_addr <= RESET_PC;
      r_imem_en       <= 1'b0;
      r_imem_addr     <= RESET_PC;
      r_ins           <= BUBBLE_INS;
      r_pres_addr     <= 32'h0;
    end else begin
      r_inflight      <= r_imem_en;
      r_inflight_addr <= r_imem_addr;
      if (w_redirect) begin
        // Target is requested right away; REDIRECT then skips one issue slot.
        r_state     <= REDIRECT;
        r_inflight  <= 1'b0;
        r_imem_en   <= 1'b1;
        r_imem_addr <= w_target;
        r_fetch_pc  <= next_pc(w_target);
        r_ins       <= BUBBLE_INS;
      end else begin
        case (r_state)
          RUN: begin
            if (w_credit) begin
              r_imem_en   <= 1'b1;
              r_imem_addr <= r_fetch_pc;
              r_fetch_pc  <= next_pc(r_fetch_pc);
            end else begin
              r_imem_en <= 1'b0;
            end
          end
          IDLE, REDIRECT: begin
            r_imem_en <= 1'b0;
            r_state   <= RUN;
          end
          default: begin
            r_imem_en <= 1'b0;
            r_state   <= IDLE;
          end
        endcase
        if (w_load) begin
          r_ins       <= w_load_entry.ins;
          r_pres_addr <= w_load_entry.addr;
        end else if (w_adv) begin
          r_ins <= BUBBLE_INS;
        end
      end
    end
  end

  assign imem_en         = r_imem_en;
  assign imem_addr       = r_imem_addr;
  assign ins             = r_ins;
  assign IF_ID_pres_addr = r_pres_addr;

  a_no_overflow: assert property (@(posedge clk) disable iff (Rst)
    !(w_push && w_full && !w_pop && !w_redirect));

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - self-checking bench for if_fetch_queue
module tb_if_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IF_FETCH_BYPASS_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 4;
`endif

  logic        clk = 1'b0;
  logic        Rst = 1'b1;
  logic        hz = 1'b0, f_stall = 1'b0, mem_hold = 1'b0;
  logic        branch = 1'b0, trigger_trap = 1'b0, trigger_trap_ret = 1'b0;
  logic [31:0] branoff = 32'h0, mtvec = 32'h0, mepc = 32'h0;
  logic        imem_en;
  logic [31:0] imem_addr, imem_dout, ins, IF_ID_pres_addr;

  int errs = 0;
  int checks = 0;

  if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .Rst(Rst), .hz(hz), .f_stall(f_stall), .mem_hold(mem_hold),
    .branch(branch), .branoff(branoff), .trigger_trap(trigger_trap), .mtvec(mtvec),
    .trigger_trap_ret(trigger_trap_ret), .mepc(mepc), .imem_en(imem_en),
    .imem_addr(imem_addr), .imem_dout(imem_dout), .ins(ins),
    .IF_ID_pres_addr(IF_ID_pres_addr)
  );

  always #5 clk = ~clk;

  // Instruction memory: mem[a] = a + 0x100, one-cycle read latency.
  always @(posedge clk) if (imem_en) imem_dout <= imem_addr + 32'h100;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: queue of buffered words plus the pending memory response.
  typedef struct {logic [31:0] a; logic [31:0] d;} ent_t;
  ent_t        q[$];
  ent_t        m_r;
  bit          m_rv;
  bit          m_inf = 1'b0;
  bit          armed = 1'b0;
  logic [31:0] m_inf_addr = 32'h0;
  logic [31:0] exp_ins = 32'h0, exp_addr = 32'h0, exp_fetch = RESET_PC;

  always @(negedge clk) begin
    if (armed) begin
      chk("model_ins", ins, exp_ins);
      chk("model_pres_addr", IF_ID_pres_addr, exp_addr);
      if (imem_en) chk("model_imem_addr", imem_addr, exp_fetch);
    end
    if (Rst) begin
      q.delete();
      m_inf     = 1'b0;
      exp_ins   = 32'h0;
      exp_addr  = 32'h0;
      exp_fetch = RESET_PC;
      armed     = 1'b1;
    end else if (trigger_trap || trigger_trap_ret || branch) begin
      q.delete();
      m_inf     = 1'b0;
      exp_ins   = 32'h0;
      exp_fetch = trigger_trap ? mtvec : (trigger_trap_ret ? mepc : branoff);
    end else begin
      m_rv  = m_inf;
      m_r.a = m_inf_addr;
      m_r.d = m_inf_addr + 32'h100;
      if (!(hz || f_stall || mem_hold)) begin
        if (q.size() > 0) begin
          exp_ins  = q[0].d;
          exp_addr = q[0].a;
          void'(q.pop_front());
        end
`ifdef IF_FETCH_BYPASS_EN
        else if (m_rv) begin
          exp_ins  = m_r.d;
          exp_addr = m_r.a;
          m_rv     = 1'b0;
        end
`endif
        else exp_ins = 32'h0;
      end
      if (m_rv) q.push_back(m_r);
      chk("fifo_occupancy_le_depth", {31'b0, q.size() <= DEPTH}, 32'd1);
      m_inf      = imem_en;
      m_inf_addr = exp_fetch;
      if (imem_en) exp_fetch = exp_fetch + 32'd4;
    end
  end

  bit watch40 = 1'b0, seen40 = 1'b0;
  always @(negedge clk) if (watch40 && imem_en && imem_addr == 32'h40) seen40 = 1'b1;

  task automatic wait_word(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (ins != 32'h0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  bit ok;

  initial begin
    step();
    chk("reset_ins", ins, 32'h0);
    chk("reset_pres_addr", IF_ID_pres_addr, 32'h0);
    chk("reset_imem_en", {31'b0, imem_en}, 32'd0);
    chk("reset_imem_addr", imem_addr, RESET_PC);
    step();
    step();
    Rst = 1'b0;

    wait_word(20, ok);
    chk("first_word_timeout", {31'b0, ok}, 32'd1);
    chk("first_ins", ins, 32'h100);
    chk("first_addr", IF_ID_pres_addr, 32'h0);
    step();
    chk("second_ins", ins, 32'h104);
    chk("second_addr", IF_ID_pres_addr, 32'h4);
    step();
    chk("third_ins", ins, 32'h108);
    chk("third_addr", IF_ID_pres_addr, 32'h8);

    hz = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_hold_ins", ins, 32'h108);
      chk("stall_hold_addr", IF_ID_pres_addr, 32'h8);
      if (i == 4) chk("stall_full_no_issue", {31'b0, imem_en}, 32'd0);
      step();
    end
    hz = 1'b0;
    for (int j = 0; j < 5; j++) begin
      step();
      chk("stream_ins", ins, 32'h10C + 32'(4 * j));
      chk("stream_addr", IF_ID_pres_addr, 32'hC + 32'(4 * j));
    end

    branch = 1'b1; branoff = 32'h40;
    step();
    branch = 1'b0;
    chk("branch_bubble", ins, 32'h0);
    for (int k = 2; k < LAT; k++) begin
      step();
      chk("branch_no_stale", ins, 32'h0);
    end
    step();
    chk("branch_ins", ins, 32'h140);
    chk("branch_addr", IF_ID_pres_addr, 32'h40);
    repeat (4) step();

    seen40 = 1'b0; watch40 = 1'b1;
    trigger_trap = 1'b1; mtvec = 32'h200; branch = 1'b1; branoff = 32'h40;
    step();
    trigger_trap = 1'b0; branch = 1'b0;
    chk("trap_issue_en", {31'b0, imem_en}, 32'd1);
    chk("trap_issue_addr", imem_addr, 32'h200);
    repeat (LAT - 1) step();
    chk("trap_ins", ins, 32'h300);
    chk("trap_addr", IF_ID_pres_addr, 32'h200);
    repeat (3) step();
    chk("branch_target_never_fetched", {31'b0, seen40}, 32'd0);
    watch40 = 1'b0;

    trigger_trap_ret = 1'b1; mepc = 32'h44;
    step();
    trigger_trap_ret = 1'b0;
    repeat (LAT - 1) step();
    chk("tret_ins", ins, 32'h144);
    chk("tret_addr", IF_ID_pres_addr, 32'h44);
    repeat (3) step();

    f_stall = 1'b1; branch = 1'b1; branoff = 32'h80;
    step();
    branch = 1'b0;
    chk("stall_redirect_bubble", ins, 32'h0);
    repeat (5) begin
      step();
      chk("stall_redirect_hold", ins, 32'h0);
    end
    f_stall = 1'b0;
    wait_word(10, ok);
    chk("stall_redirect_timeout", {31'b0, ok}, 32'd1);
    chk("stall_redirect_ins", ins, 32'h180);
    chk("stall_redirect_addr", IF_ID_pres_addr, 32'h80);
    step();
    chk("stall_redirect_next", ins, 32'h184);

    hz = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 3) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk("fill_to_three_timeout", {31'b0, ok}, 32'd1);
    Rst = 1'b1;
    step();
    chk("midreset_ins", ins, 32'h0);
    chk("midreset_addr", IF_ID_pres_addr, 32'h0);
    chk("midreset_imem_en", {31'b0, imem_en}, 32'd0);
    Rst = 1'b0; hz = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (imem_en) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk("restart_issue_timeout", {31'b0, ok}, 32'd1);
    chk("restart_imem_addr", imem_addr, RESET_PC);
    wait_word(20, ok);
    chk("restart_word_timeout", {31'b0, ok}, 32'd1);
    chk("restart_ins", ins, 32'h100);
    chk("restart_addr", IF_ID_pres_addr, 32'h0);
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
